// File: rtl/sprite_eval.sv
// Per-line sprite evaluator: scans OAM through a one-cycle-latency read port and
// keeps up to LINE_MAX hits sorted by X, with the tile row already resolved.
`timescale 1ns/1ps
module sprite_eval #(
  parameter int SPRITE_COUNT = 40,
  parameter int LINE_MAX     = 10,
  parameter int IDX_W        = 6,
  parameter int CNT_W        = 4
) (
  input  logic             clockgb,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       line,
  input  logic             tall,
  output logic [IDX_W-1:0] oam_index,
  input  logic [7:0]       oam_y,
  input  logic [7:0]       oam_x,
  input  logic [7:0]       oam_tile,
  input  logic [7:0]       oam_attr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] slot_sel,
  output logic [7:0]       slot_x,
  output logic [7:0]       slot_tile,
  output logic [7:0]       slot_attr,
  output logic [2:0]       slot_row
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r, state_s;
  logic [7:0]       line_r;
  logic             tall_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] eval_idx_r;
  logic             eval_vld_r;
  logic [CNT_W-1:0] count_r;
  logic             busy_r, done_r;

  logic [7:0] slot_x_r    [LINE_MAX];
  logic [7:0] slot_tile_r [LINE_MAX];
  logic [7:0] slot_attr_r [LINE_MAX];
  logic [2:0] slot_row_r  [LINE_MAX];

  logic [8:0]       diff_s;
  logic [4:0]       h_s;
  logic             hit_s;
  logic [3:0]       row_s;
  logic [7:0]       tile_s;
  logic [CNT_W-1:0] pos_s;
  logic             ins_s;

  assign oam_index = idx_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign count     = count_r;

  // Hit test, row/tile resolution and stable sorted insert position for the entry on the OAM bus
  always_comb begin
    diff_s = {1'b0, line_r} + 9'd16 - {1'b0, oam_y};
    h_s    = tall_r ? 5'd16 : 5'd8;
    hit_s  = (diff_s < {4'd0, h_s});
    if (oam_attr[6]) begin
      row_s = tall_r ? (4'd15 - diff_s[3:0]) : (4'd7 - diff_s[3:0]);
    end else begin
      row_s = diff_s[3:0];
    end
    tile_s = tall_r ? {oam_tile[7:1], row_s[3]} : oam_tile;
    // Equal X counts as "before", so a later OAM entry lands behind earlier ones
    pos_s = '0;
    for (int i = 0; i < LINE_MAX; i++) begin
      if ((CNT_W'(i) < count_r) && (slot_x_r[i] <= oam_x)) begin
        pos_s = pos_s + CNT_W'(1);
      end else begin
        pos_s = pos_s;
      end
    end
    ins_s = (state_r == SCAN) && eval_vld_r && hit_s && (count_r < CNT_W'(LINE_MAX));
  end

  // Next-state logic; start restarts from any state
  always_comb begin
    state_s = state_r;
    if (start) begin
      state_s = SCAN;
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        SCAN: begin
          if (ins_s && (count_r == CNT_W'(LINE_MAX - 1))) begin
            state_s = DONE;
          end else if (eval_vld_r && (eval_idx_r == IDX_W'(SPRITE_COUNT - 1))) begin
            state_s = DONE;
          end else begin
            state_s = SCAN;
          end
        end
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register with busy/done registered alongside it
  always_ff @(posedge clockgb or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == SCAN);
      done_r  <= (state_s == DONE);
    end
  end

  // Scan address pipeline and slot list maintenance
  always_ff @(posedge clockgb or posedge reset) begin
    if (reset) begin
      line_r     <= 8'd0;
      tall_r     <= 1'b0;
      idx_r      <= '0;
      eval_idx_r <= '0;
      eval_vld_r <= 1'b0;
      count_r    <= '0;
      for (int i = 0; i < LINE_MAX; i++) begin
        slot_x_r[i]    <= 8'd0;
        slot_tile_r[i] <= 8'd0;
        slot_attr_r[i] <= 8'd0;
        slot_row_r[i]  <= 3'd0;
      end
    end else if (start) begin
      line_r     <= line;
      tall_r     <= tall;
      idx_r      <= '0;
      eval_idx_r <= '0;
      eval_vld_r <= 1'b0;
      count_r    <= '0;
    end else if (state_r == SCAN) begin
      idx_r      <= (idx_r == IDX_W'(SPRITE_COUNT - 1)) ? idx_r : idx_r + IDX_W'(1);
      eval_idx_r <= idx_r;
      eval_vld_r <= 1'b1;
      if (ins_s) begin
        for (int i = LINE_MAX - 1; i > 0; i--) begin
          if (CNT_W'(i) > pos_s) begin
            slot_x_r[i]    <= slot_x_r[i-1];
            slot_tile_r[i] <= slot_tile_r[i-1];
            slot_attr_r[i] <= slot_attr_r[i-1];
            slot_row_r[i]  <= slot_row_r[i-1];
          end
        end
        slot_x_r[pos_s]    <= oam_x;
        slot_tile_r[pos_s] <= tile_s;
        slot_attr_r[pos_s] <= oam_attr;
        slot_row_r[pos_s]  <= row_s[2:0];
        count_r            <= count_r + CNT_W'(1);
      end
    end else begin
      eval_vld_r <= 1'b0;
    end
  end

  // Slot read port; unused slots read as zero
  always_comb begin
    if (slot_sel < count_r) begin
      slot_x    = slot_x_r[slot_sel];
      slot_tile = slot_tile_r[slot_sel];
      slot_attr = slot_attr_r[slot_sel];
      slot_row  = slot_row_r[slot_sel];
    end else begin
      slot_x    = 8'd0;
      slot_tile = 8'd0;
      slot_attr = 8'd0;
      slot_row  = 3'd0;
    end
  end

endmodule

// File: tb/tb_sprite_eval.sv
// Scoreboard bench for sprite_eval: a queue-based reference model predicts each
// scan's slot list and done cycle; a monitor checks them when done pulses.
`timescale 1ns/1ps
module tb_sprite_eval;
  localparam int SC = 40;
  localparam int LM = 10;

  logic       clockgb = 1'b0;
  logic       reset   = 1'b1;
  logic       start   = 1'b0;
  logic [7:0] line    = 8'd0;
  logic       tall    = 1'b0;
  logic [5:0] oam_index;
  logic [7:0] oam_y = 8'd0, oam_x = 8'd0, oam_tile = 8'd0, oam_attr = 8'd0;
  logic       busy, done;
  logic [3:0] count;
  logic [3:0] slot_sel = 4'd0;
  logic [7:0] slot_x, slot_tile, slot_attr;
  logic [2:0] slot_row;

  sprite_eval #(.SPRITE_COUNT(SC), .LINE_MAX(LM), .IDX_W(6), .CNT_W(4)) dut (
    .clockgb(clockgb), .reset(reset), .start(start), .line(line), .tall(tall),
    .oam_index(oam_index), .oam_y(oam_y), .oam_x(oam_x), .oam_tile(oam_tile),
    .oam_attr(oam_attr), .busy(busy), .done(done), .count(count),
    .slot_sel(slot_sel), .slot_x(slot_x), .slot_tile(slot_tile),
    .slot_attr(slot_attr), .slot_row(slot_row));

  always #5 clockgb = ~clockgb;

  logic [7:0] oy [SC];
  logic [7:0] ox [SC];
  logic [7:0] ot [SC];
  logic [7:0] oa [SC];

  // OAM memory with a one-cycle synchronous read
  always @(posedge clockgb) begin
    oam_y    <= oy[oam_index];
    oam_x    <= ox[oam_index];
    oam_tile <= ot[oam_index];
    oam_attr <= oa[oam_index];
  end

  int cyc = 0;
  always @(posedge clockgb) cyc <= cyc + 1;

  typedef struct packed {
    int cyc;
    int cnt;
    int last;
    logic [LM-1:0][7:0] x;
    logic [LM-1:0][7:0] tile;
    logic [LM-1:0][7:0] attr;
    logic [LM-1:0][2:0] row;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Walk OAM in order, keep hits in a list ordered by X (ties keep OAM order)
  function automatic exp_t model(input logic [7:0] l, input logic t);
    exp_t e;
    int   n;
    e      = '0;
    n      = 0;
    e.last = SC - 1;
    for (int i = 0; i < SC; i++) begin
      int diff;
      int h;
      int r;
      int p;
      logic [3:0] rb;
      diff = (int'(l) + 16 - int'(oy[i]) + 512) % 512;
      h    = t ? 16 : 8;
      if (diff < h) begin
        r  = oa[i][6] ? (h - 1 - diff) : diff;
        rb = 4'(r);
        p  = n;
        while (p > 0 && e.x[p-1] > ox[i]) begin
          e.x[p]    = e.x[p-1];
          e.tile[p] = e.tile[p-1];
          e.attr[p] = e.attr[p-1];
          e.row[p]  = e.row[p-1];
          p--;
        end
        e.x[p]    = ox[i];
        e.tile[p] = t ? {ot[i][7:1], rb[3]} : ot[i];
        e.attr[p] = oa[i];
        e.row[p]  = rb[2:0];
        n++;
        if (n == LM) begin
          e.last = i;
          break;
        end
      end
    end
    e.cnt = n;
    return e;
  endfunction

  task automatic issue_start(input logic [7:0] l, input logic t);
    exp_t e;
    e = model(l, t);
    @(negedge clockgb);
    line  = l;
    tall  = t;
    start = 1'b1;
    e.cyc = cyc + 1 + e.last + 2;
    q.push_back(e);
    @(negedge clockgb);
    start = 1'b0;
    line  = 8'($urandom);
    tall  = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clockgb);
      n++;
    end
    chk("done_timeout", q.size(), 0);
    @(negedge clockgb);
    chk("busy_after_done", int'(busy), 0);
  endtask

  task automatic clear_oam();
    for (int i = 0; i < SC; i++) begin
      oy[i] = 8'd0;
      ox[i] = 8'($urandom);
      ot[i] = 8'($urandom);
      oa[i] = 8'($urandom);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clockgb);
      if (!reset && done) begin
        chk("done_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("count", int'(count), e.cnt);
          for (int s = 0; s < 16; s++) begin
            slot_sel = 4'(s);
            #0.1;
            if (s < e.cnt) begin
              chk("slot_x", int'(slot_x), int'(e.x[s]));
              chk("slot_tile", int'(slot_tile), int'(e.tile[s]));
              chk("slot_attr", int'(slot_attr), int'(e.attr[s]));
              chk("slot_row", int'(slot_row), int'(e.row[s]));
            end else begin
              chk("slot_x_empty", int'(slot_x), 0);
              chk("slot_tile_empty", int'(slot_tile), 0);
              chk("slot_attr_empty", int'(slot_attr), 0);
              chk("slot_row_empty", int'(slot_row), 0);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] l;
    clear_oam();
    repeat (3) @(negedge clockgb);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_index", int'(oam_index), 0);
    reset = 1'b0;
    @(negedge clockgb);

    // All y=0: nothing hits, full-length scan
    issue_start(8'd50, 1'b0);
    chk("busy_in_scan", int'(busy), 1);
    wait_idle();

    // Three hits with an X tie
    clear_oam();
    oy[3] = 8'd66; ox[3] = 8'd40;
    oy[7] = 8'd66; ox[7] = 8'd20;
    oy[9] = 8'd66; ox[9] = 8'd40;
    issue_start(8'd50, 1'b0);
    wait_idle();

    // Twelve hits: list fills after index 9
    clear_oam();
    for (int i = 0; i < 12; i++) oy[i] = 8'd66;
    issue_start(8'd50, 1'b0);
    wait_idle();

    // Tall sprite, without and with Y-flip
    clear_oam();
    oy[5] = 8'd60; ot[5] = 8'h35; oa[5] = 8'h00;
    issue_start(8'd55, 1'b1);
    wait_idle();
    oa[5] = 8'h40;
    issue_start(8'd55, 1'b1);
    wait_idle();

    // Abort by re-issuing start with a different line
    for (int i = 0; i < SC; i++) oy[i] = (i % 4 == 0) ? 8'd62 : ((i % 2 == 1) ? 8'd72 : 8'd200);
    issue_start(8'd50, 1'b0);
    repeat (8) @(negedge clockgb);
    void'(q.pop_back());
    issue_start(8'd60, 1'b0);
    wait_idle();

    // Reset mid-scan discards the scan
    issue_start(8'd60, 1'b0);
    repeat (5) @(negedge clockgb);
    #1 reset = 1'b1;
    q.delete();
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_done", int'(done), 0);
    repeat (2) @(negedge clockgb);
    reset = 1'b0;
    repeat (60) @(negedge clockgb);
    issue_start(8'd60, 1'b0);
    wait_idle();

    // Randomized scans
    for (int k = 0; k < 25; k++) begin
      l = 8'($urandom_range(0, 143));
      for (int i = 0; i < SC; i++) begin
        oy[i] = ($urandom_range(0, 2) == 0) ? 8'(l + 8'($urandom_range(0, 23))) : 8'($urandom);
        ox[i] = 8'($urandom_range(0, 15));
        ot[i] = 8'($urandom);
        oa[i] = 8'($urandom);
      end
      issue_start(l, 1'($urandom));
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
